// File: rtl/iter_fold_pkg.sv
// Shared types and the single-step carry-fold function for the iterative fold engine.
package iter_fold_pkg;

  localparam int unsigned FOLD_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fold_state_e;

  typedef enum logic {
    FOLD_ROUND = 1'b0,
    FOLD_TRUNC = 1'b1
  } fold_mode_e;

  typedef struct packed {
    logic                  carry;
    logic [FOLD_MAX_W-1:0] value;
  } fold_step_t;

  // One fold step on a zero-extended value; also usable as a constant function.
  function automatic fold_step_t fold_step(input logic [FOLD_MAX_W-1:0] value,
                                           input logic                  carry,
                                           input fold_mode_e            mode);
    fold_step_t r;
    logic       b;
    b = value[0];
    if (mode == FOLD_ROUND) begin
      r.value = (value >> 1) + FOLD_MAX_W'(b);
      r.carry = b;
    end else begin
      r.value = value >> 1;
      r.carry = carry | b;
    end
    return r;
  endfunction

endpackage

// File: rtl/iter_fold_lane.sv
// One channel of the fold engine: value and carry registers, loaded from seed or stepped.
module iter_fold_lane
  import iter_fold_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  fold_mode_e        mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] value,
  output logic              carry
);

  fold_step_t nxt;

  always_comb begin
    nxt = fold_step(FOLD_MAX_W'(value), carry, mode);
  end

  // Load takes priority; a fresh run always starts with a clear carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      carry <= 1'b0;
    end else if (load) begin
      value <= seed;
      carry <= 1'b0;
    end else if (step) begin
      value <= DATA_W'(nxt.value);
      carry <= nxt.carry;
    end
  end

endmodule

// File: rtl/iter_fold_engine.sv
// Multi-lane sequential carry-fold engine: shared FSM/counter driving NUM_CH fold lanes.
module iter_fold_engine
  import iter_fold_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned NUM_CH   = 2,
  parameter  int unsigned MAX_ITER = 10,
  localparam int unsigned CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic                     CLK_CI,
  input  logic                     RST_RBI,
  input  logic                     Start_SI,
  input  logic                     Mode_SI,
  input  logic [CNT_W-1:0]         Iter_DI,
  input  logic [NUM_CH*DATA_W-1:0] Seed_DI,
  output logic                     Busy_SO,
  output logic                     Finish_SO,
  output logic [NUM_CH*DATA_W-1:0] Result_DO,
  output logic [NUM_CH-1:0]        Carry_DO
);

  fold_state_e      state_q, state_d;
  fold_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] iter_clamped;
  logic             load_c;
  logic             step_c;

  assign iter_clamped = (Iter_DI > CNT_W'(MAX_ITER)) ? CNT_W'(MAX_ITER) : Iter_DI;

  // Next-state logic; starts are only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start_SI) begin
          load_c  = 1'b1;
          mode_d  = fold_mode_e'(Mode_SI);
          cnt_d   = iter_clamped;
          state_d = (iter_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy/Finish are registered decodes of the next state.
  always_ff @(posedge CLK_CI or negedge RST_RBI) begin
    if (!RST_RBI) begin
      state_q   <= IDLE;
      mode_q    <= FOLD_ROUND;
      cnt_q     <= '0;
      Busy_SO   <= 1'b0;
      Finish_SO <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      Busy_SO   <= (state_d == RUN);
      Finish_SO <= (state_d == DONE);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    iter_fold_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk   (CLK_CI),
      .rst_n (RST_RBI),
      .load  (load_c),
      .step  (step_c),
      .mode  (mode_q),
      .seed  (Seed_DI[k*DATA_W +: DATA_W]),
      .value (Result_DO[k*DATA_W +: DATA_W]),
      .carry (Carry_DO[k])
    );
  end

endmodule

// File: tb/tb_iter_fold_engine.sv
// Directed scoreboard bench for iter_fold_engine.
module tb_iter_fold_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned MI = 10;
  localparam int unsigned CW = $clog2(MI + 1);
  localparam int unsigned SW = NC * DW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode  = 1'b0;
  logic [CW-1:0] iter  = '0;
  logic [SW-1:0] seed  = '0;
  logic          busy;
  logic          finish;
  logic [SW-1:0] result;
  logic [NC-1:0] carry;

  typedef struct {
    logic [SW-1:0] res;
    logic [NC-1:0] cy;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  iter_fold_engine #(
    .DATA_W  (DW),
    .NUM_CH  (NC),
    .MAX_ITER(MI)
  ) dut (
    .CLK_CI   (clk),
    .RST_RBI  (rst_n),
    .Start_SI (start),
    .Mode_SI  (mode),
    .Iter_DI  (iter),
    .Seed_DI  (seed),
    .Busy_SO  (busy),
    .Finish_SO(finish),
    .Result_DO(result),
    .Carry_DO (carry)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: round is ceil(v/2) with carry = last low bit; truncate is floor with sticky OR.
  function automatic void model(input logic [SW-1:0] s, input int n, input logic m,
                                output logic [SW-1:0] res, output logic [NC-1:0] cy);
    for (int l = 0; l < NC; l++) begin
      logic [DW:0] v;
      logic        c;
      v = {1'b0, s[l*DW +: DW]};
      c = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (!m) begin
          c = v[0];
          v = (v + 1'b1) >> 1;
        end else begin
          c = c | v[0];
          v = v >> 1;
        end
      end
      res[l*DW +: DW] = v[DW-1:0];
      cy[l]           = c;
    end
  endfunction

  task automatic do_run(input logic [SW-1:0] s, input int it, input logic m,
                        input bit pulse_mid, output logic [SW-1:0] final_res);
    int            n;
    exp_t          e;
    exp_t          got;
    logic [SW-1:0] r;
    logic [NC-1:0] c;
    n = (it > int'(MI)) ? int'(MI) : it;
    model(s, n, m, e.res, e.cy);
    sb.push_back(e);
    final_res = e.res;
    seed  = s;
    iter  = CW'(it);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = SW'($urandom);
    iter  = CW'($urandom);
    mode  = ~m;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      model(s, k - 1, m, r, c);
      chk($sformatf("busy k=%0d", k), 64'(busy), 64'(k <= n));
      chk($sformatf("finish k=%0d", k), 64'(finish), 64'(k == n + 1));
      chk($sformatf("result k=%0d", k), 64'(result), 64'(r));
      chk($sformatf("carry k=%0d", k), 64'(carry), 64'(c));
      if (pulse_mid && k == 2) start = 1'b1;
      if (pulse_mid && k == 3) start = 1'b0;
      if (finish) begin
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("sb_result", 64'(result), 64'(got.res));
          chk("sb_carry", 64'(carry), 64'(got.cy));
        end else begin
          n_total++;
          $error("FAIL sb_underflow observed=finish expected=no_finish");
        end
      end
    end
  endtask

  task automatic idle_check(input logic [SW-1:0] held);
    @(negedge clk);
    chk("idle_finish", 64'(finish), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_hold", 64'(result), 64'(held));
  endtask

  initial begin
    logic [SW-1:0] fr;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_finish", 64'(finish), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_carry", 64'(carry), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    do_run(16'h0007, 3, 1'b0, 1'b0, fr);
    idle_check(fr);
    do_run(16'h0007, 3, 1'b1, 1'b0, fr);
    idle_check(fr);
    do_run(16'h0080, 15, 1'b0, 1'b0, fr);
    idle_check(fr);
    do_run(16'h00A5, 0, 1'b0, 1'b0, fr);
    idle_check(fr);
    do_run(16'h02FF, 1, 1'b0, 1'b0, fr);
    do_run(16'h3C91, 5, 1'b1, 1'b1, fr);
    idle_check(fr);
    do_run(16'hB64D, 4, 1'b0, 1'b1, fr);
    do_run(16'h1E70, 2, 1'b1, 1'b0, fr);
    idle_check(fr);

    // Abort a 5-step run during its second RUN cycle.
    seed  = 16'h5A33;
    iter  = CW'(5);
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_finish", 64'(finish), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_carry", 64'(carry), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("post_abort_finish k=%0d", k), 64'(finish), 64'(0));
      chk($sformatf("post_abort_busy k=%0d", k), 64'(busy), 64'(0));
    end
    do_run(16'hC3E7, 4, 1'b0, 1'b0, fr);
    idle_check(fr);

    chk("sb_drain", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iter_fold_engine.md
Name: iter_fold_engine

Overview:
- Multi-channel sequential carry-fold engine.
- Each channel iterates v <= (v >> 1) + v[0] for a runtime-programmed iteration count, one step per clock.
- Hardware successor to the elaboration-time fold function used for parameter derivation.
- Adds runtime iteration count, NUM_CH parallel lanes, rounding/truncating mode, sticky carry and a start/finish handshake.

Parameters:
- DATA_W, 8: bits per channel value (>= 2).
- NUM_CH, 2: number of parallel lanes (>= 1).
- MAX_ITER, 10: maximum iterations per run (>= 1); larger requests are clamped to this.
- CNT_W, localparam = $clog2(MAX_ITER+1): iteration counter width.

Ports:
- CLK_CI  input  1  clock, rising edge.
- RST_RBI  input  1  asynchronous active-low reset.
- Start_SI  input  1  start request, sampled on rising edge.
- Mode_SI  input  1  0 = round (add shifted-out bit), 1 = truncate; latched at start.
- Iter_DI  input  CNT_W  requested iteration count; latched at start.
- Seed_DI  input  NUM_CH*DATA_W  initial values; lane k is [k*DATA_W +: DATA_W]; latched at start.
- Busy_SO  output  1  high while in RUN.
- Finish_SO  output  1  one-cycle completion pulse.
- Result_DO  output  NUM_CH*DATA_W  final lane values; held until the next accepted start.
- Carry_DO  output  NUM_CH  per-lane carry flag; meaning depends on mode.

Behaviour:
- Reset (async assert, synchronous release):
  - State IDLE.
  - Busy_SO = 0, Finish_SO = 0, Result_DO = 0, Carry_DO = 0.
  - Internal counter and latched mode cleared.
  - Reset during RUN aborts the run; no Finish_SO pulse follows.
- States: IDLE, RUN, DONE (enum in package).
- Start is accepted only in IDLE or DONE. Start_SI in RUN is ignored and not queued.
- Accept at edge E0:
  - Latch N = min(Iter_DI, MAX_ITER), Mode_SI and Seed_DI.
  - N = 0: next state DONE, Result_DO = seed, Carry_DO = 0.
  - N > 0: next state RUN, cnt = N, lane values = seed, lane carries = 0.
- Each RUN edge, per lane, with b = v[0]:
  - Round mode: v <= (v >> 1) + b; carry <= b, i.e. the last shifted-out bit.
  - Truncate mode: v <= v >> 1; carry <= carry | b, i.e. a sticky OR of all shifted-out bits.
  - The sum is DATA_W wide and cannot overflow, since (v >> 1) <= 2^(DATA_W-1) - 1. No wrap logic is required.
  - cnt decrements. On the edge where cnt == 1, the step is applied and the next state is DONE.
- Result_DO and Carry_DO update on every step; they are final once DONE is entered.
- Latency:
  - Finish_SO is high exactly for the cycle following edge E0+N.
  - Busy_SO is high for N cycles (zero cycles when N = 0).
- DONE lasts one cycle, then returns to IDLE unless a new start is accepted in DONE, which gives back-to-back runs.
- Finish_SO = (state == DONE).
- All lanes share cnt, mode and state; lanes differ only in data.

Decomposition:
- iter_fold_pkg:
  - fold_state_e {IDLE, RUN, DONE}.
  - fold_mode_e {FOLD_ROUND, FOLD_TRUNC}.
  - Function fold_step(value, carry, mode), returning the next value and carry. The same function is usable at elaboration time for localparam derivation.
- iter_fold_lane sub-module: one channel's value and carry registers.
  - Inputs: load, step, mode, seed.
  - Instantiated NUM_CH times by generate.
  - The FSM and counter stay in the top level.

Test Plan:
- DATA_W=8, lane0 seed 0x07, Iter=3, round mode -> lane steps 0x04, 0x02, 0x01; Result 0x01, Carry 0; Finish_SO high in the cycle after E0+3; Busy_SO high for 3 cycles.
- Same seed 0x07, Iter=3, truncate mode -> steps 0x03, 0x01, 0x00; Result 0x00, Carry 1 (sticky).
- Seed 0x80, Iter=15 with MAX_ITER=10, round mode -> clamped to 10 steps; Result 0x01, Carry 1; Busy_SO high for exactly 10 cycles.
- Iter=0, seed 0xA5 -> Finish_SO high in the cycle after E0; Busy_SO never high; Result 0xA5, Carry 0.
- Two lanes, seeds 0xFF / 0x02, Iter=1, round mode -> Results 0x80 / 0x01, Carries 1 / 0. Start_SI pulsed mid-RUN is ignored. A start held during the DONE cycle launches a new run.
- RST_RBI asserted during RUN cycle 2 of 5 -> all outputs 0 immediately; state IDLE; no Finish_SO pulse after release; the next start runs normally.
